// File: rtl/red_pitaya_decimator_block.sv
// Decimating boxcar averager: per window of 2^L samples emits the floor mean,
// maximum and minimum of the filtered stream, flagged by a one-cycle valid strobe.
module red_pitaya_decimator_block #(
    parameter int SIGNALBITS = 14,
    parameter int MAXLOG2    = 10
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         enable_i,
    input  logic                         sync_i,
    input  logic [3:0]                   log2_dec_i,
    input  logic signed [SIGNALBITS-1:0] dat_i,
    output logic signed [SIGNALBITS-1:0] dat_o,
    output logic signed [SIGNALBITS-1:0] max_o,
    output logic signed [SIGNALBITS-1:0] min_o,
    output logic                         valid_o
);

    localparam int AW = SIGNALBITS + MAXLOG2;
    localparam logic [MAXLOG2:0] ONE_W = (MAXLOG2+1)'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_base, sum;
    logic [MAXLOG2-1:0]      cnt_q, cnt_base;
    logic [3:0]              l_q, l_req, l_cur;
    logic signed [SIGNALBITS-1:0] max_q, min_q, max_nx, min_nx;
    logic [MAXLOG2:0]        n_win;
    logic                    first, last;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = enable_i ? RUN : IDLE;
        l_req    = (log2_dec_i > 4'(MAXLOG2)) ? 4'(MAXLOG2) : log2_dec_i;
        // A sample opens a new window after idle, after a completed window, or on sync.
        first    = sync_i || (state_q == IDLE) || (cnt_q == '0);
        l_cur    = first ? l_req : l_q;
        acc_base = first ? '0 : acc_q;
        cnt_base = first ? '0 : cnt_q;
        sum      = acc_base + AW'(dat_i);
        max_nx   = (first || dat_i > max_q) ? dat_i : max_q;
        min_nx   = (first || dat_i < min_q) ? dat_i : min_q;
        n_win    = ONE_W << l_cur;
        last     = ({1'b0, cnt_base} == (n_win - ONE_W));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            l_q     <= '0;
            max_q   <= '0;
            min_q   <= '0;
            dat_o   <= '0;
            max_o   <= '0;
            min_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_o <= 1'b0;
            if (!enable_i) begin
                acc_q <= '0;
                cnt_q <= '0;
                max_q <= '0;
                min_q <= '0;
            end else if (last) begin
                acc_q   <= '0;
                cnt_q   <= '0;
                l_q     <= l_cur;
                max_q   <= max_nx;
                min_q   <= min_nx;
                dat_o   <= SIGNALBITS'(sum >>> l_cur);
                max_o   <= max_nx;
                min_o   <= min_nx;
                valid_o <= 1'b1;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_base + MAXLOG2'(1);
                l_q   <= l_cur;
                max_q <= max_nx;
                min_q <= min_nx;
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_decimator_block.sv
// Self-checking bench: a queue-based window model predicts every output each cycle;
// literal expectations on the model's window log pin the model itself.
module tb_red_pitaya_decimator_block;

    localparam int SB = 14;
    localparam int ML = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic enable = 1'b0;
    logic sync = 1'b0;
    logic [3:0] log2_dec = '0;
    logic signed [SB-1:0] dat = '0;
    logic signed [SB-1:0] dat_o, max_o, min_o;
    logic valid_o;

    red_pitaya_decimator_block #(.SIGNALBITS(SB), .MAXLOG2(ML)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .enable_i   (enable),
        .sync_i     (sync),
        .log2_dec_i (log2_dec),
        .dat_i      (dat),
        .dat_o      (dat_o),
        .max_o      (max_o),
        .min_o      (min_o),
        .valid_o    (valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: collect the window's samples, reduce when it is full.
    typedef struct {
        longint mean;
        longint mx;
        longint mn;
        int     cyc;
    } win_t;

    longint q[$];
    win_t   log_q[$];
    int     lw = 0;
    int     cyc = 0;
    longint exp_dat = 0, exp_max = 0, exp_min = 0;
    bit     exp_valid = 1'b0;

    always @(posedge clk or negedge rstn) begin : model
        longint s, mx, mn;
        win_t w;
        if (!rstn) begin
            q.delete();
            exp_dat = 0; exp_max = 0; exp_min = 0; exp_valid = 1'b0;
        end else begin
            cyc++;
            exp_valid = 1'b0;
            if (!enable) begin
                q.delete();
            end else begin
                if (sync || q.size() == 0) begin
                    q.delete();
                    lw = (int'(log2_dec) > ML) ? ML : int'(log2_dec);
                end
                q.push_back(longint'(dat));
                if (q.size() == (1 << lw)) begin
                    s = 0; mx = q[0]; mn = q[0];
                    foreach (q[i]) begin
                        s += q[i];
                        if (q[i] > mx) mx = q[i];
                        if (q[i] < mn) mn = q[i];
                    end
                    exp_dat = s >>> lw;
                    exp_max = mx;
                    exp_min = mn;
                    exp_valid = 1'b1;
                    w.mean = exp_dat; w.mx = mx; w.mn = mn; w.cyc = cyc;
                    log_q.push_back(w);
                    q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        check("valid_o", longint'(valid_o), longint'(exp_valid));
        check("dat_o", longint'(dat_o), exp_dat);
        check("max_o", longint'(max_o), exp_max);
        check("min_o", longint'(min_o), exp_min);
    end

    task automatic step(input logic en, input logic sy, input logic [3:0] l, input int d);
        @(negedge clk);
        enable = en;
        sync = sy;
        log2_dec = l;
        dat = SB'(d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'd0, 0);
    endtask

    task automatic check_win(input string nm, input int idx,
                             input longint m, input longint mx, input longint mn);
        if (idx >= log_q.size()) begin
            check({nm, "_present"}, log_q.size(), idx + 1);
        end else begin
            check({nm, "_mean"}, log_q[idx].mean, m);
            check({nm, "_max"}, log_q[idx].mx, mx);
            check({nm, "_min"}, log_q[idx].mn, mn);
        end
    endtask

    function automatic int win_cyc(input int idx);
        return (idx < log_q.size()) ? log_q[idx].cyc : -1;
    endfunction

    initial begin : stim
        int base;
        int sync_cyc;
        int t1 [8] = '{1, 2, 3, 4, 5, 5, 5, 5};

        repeat (3) @(negedge clk);
        check("reset_dat", longint'(dat_o), 0);
        check("reset_valid", longint'(valid_o), 0);
        rstn = 1'b1;
        idle(2);

        // Two back-to-back windows, enable dropped on the edge after the last sample.
        base = log_q.size();
        foreach (t1[i]) step(1'b1, 1'b0, 4'd2, t1[i]);
        idle(3);
        check("t1_count", log_q.size() - base, 2);
        check_win("t1_w0", base, 2, 4, 1);
        check_win("t1_w1", base + 1, 5, 5, 5);
        check("t1_spacing", win_cyc(base + 1) - win_cyc(base), 4);

        // Negative sum floors toward -inf.
        base = log_q.size();
        step(1'b1, 1'b0, 4'd2, -1);
        step(1'b1, 1'b0, 4'd2, -1);
        step(1'b1, 1'b0, 4'd2, -1);
        step(1'b1, 1'b0, 4'd2, -2);
        idle(3);
        check("t2_count", log_q.size() - base, 1);
        check_win("t2_w0", base, -2, -1, -2);

        // Requested length clamps to 2^10; full-scale sums must not wrap.
        base = log_q.size();
        repeat (1024) step(1'b1, 1'b0, 4'd15, 8191);
        repeat (1024) step(1'b1, 1'b0, 4'd15, -8192);
        idle(3);
        check("t3_count", log_q.size() - base, 2);
        check_win("t3_w0", base, 8191, 8191, 8191);
        check_win("t3_w1", base + 1, -8192, -8192, -8192);
        check("t3_spacing", win_cyc(base + 1) - win_cyc(base), 1024);

        // Sync on the 5th sample restarts the window from the sync sample.
        base = log_q.size();
        repeat (4) step(1'b1, 1'b0, 4'd3, 100);
        step(1'b1, 1'b1, 4'd3, 1);
        sync_cyc = cyc + 1;
        for (int v = 2; v <= 8; v++) step(1'b1, 1'b0, 4'd3, v);
        idle(3);
        check("t4_count", log_q.size() - base, 1);
        check_win("t4_w0", base, 4, 8, 1);
        check("t4_latency", win_cyc(base) - sync_cyc, 7);

        // Length change mid-window applies to the next window; then L=0 passthrough.
        base = log_q.size();
        step(1'b1, 1'b0, 4'd2, 10);
        step(1'b1, 1'b0, 4'd2, 20);
        step(1'b1, 1'b0, 4'd1, 30);
        step(1'b1, 1'b0, 4'd1, 40);
        step(1'b1, 1'b0, 4'd1, 6);
        step(1'b1, 1'b0, 4'd1, 7);
        step(1'b1, 1'b0, 4'd1, -3);
        step(1'b1, 1'b0, 4'd1, -4);
        step(1'b1, 1'b0, 4'd0, 5);
        step(1'b1, 1'b0, 4'd0, -6);
        step(1'b1, 1'b0, 4'd0, 7);
        idle(1);
        check("t5_count", log_q.size() - base, 6);
        check_win("t5_w0", base, 25, 40, 10);
        check_win("t5_w1", base + 1, 6, 7, 6);
        check_win("t5_w2", base + 2, -4, -3, -4);
        check_win("t5_w3", base + 3, 5, 5, 5);
        check_win("t5_w5", base + 5, 7, 7, 7);
        check("t5_l0_spacing", win_cyc(base + 5) - win_cyc(base + 3), 2);

        // Asynchronous reset between edges clears outputs at once.
        base = log_q.size();
        step(1'b1, 1'b0, 4'd2, 9);
        step(1'b1, 1'b0, 4'd2, 9);
        #7;
        rstn = 1'b0;
        #1;
        check("async_rst_dat", longint'(dat_o), 0);
        check("async_rst_max", longint'(max_o), 0);
        check("async_rst_min", longint'(min_o), 0);
        check("async_rst_valid", longint'(valid_o), 0);
        enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        idle(1);

        // Enable dropped mid-window discards the partial window and holds outputs.
        repeat (4) step(1'b1, 1'b0, 4'd2, 8);
        repeat (2) step(1'b1, 1'b0, 4'd2, 1);
        idle(3);
        repeat (4) step(1'b1, 1'b0, 4'd2, 2);
        idle(2);
        check("t6_count", log_q.size() - base, 2);
        check_win("t6_w0", base, 8, 8, 8);
        check_win("t6_w1", base + 1, 2, 2, 2);
        check("t6_spacing", win_cyc(base + 1) - win_cyc(base), 9);

        // Randomized run; the per-cycle compare carries the checking.
        begin
            logic [3:0] l_r;
            l_r = 4'd2;
            for (int i = 0; i < 6000; i++) begin
                if (i % 64 == 0) l_r = 4'($urandom_range(0, 5));
                if (i % 1500 == 700) l_r = 4'($urandom_range(11, 15));
                step(($urandom_range(0, 127) != 0), ($urandom_range(0, 99) == 0),
                     l_r, int'($urandom_range(0, 16383)) - 8192);
            end
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
